// File: rtl/mram_ctrl_pkg.sv
// Shared types and default timing for the MRAM strobe sequencer.
package mram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RD_ACC,
        ST_RD_DONE,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RECOVER
    } state_t;

    localparam int DEF_AW       = 12;
    localparam int DEF_DW       = 16;
    localparam int DEF_RD_WAIT  = 3;
    localparam int DEF_WR_PULSE = 3;
    localparam int DEF_SETUP    = 1;
    localparam int DEF_RECOVER  = 1;
    localparam int CNT_W        = 8;

    // Request record at the default bus widths.
    typedef struct packed {
        logic              we;
        logic [DEF_AW-1:0] addr;
        logic [1:0]        be;
        logic [DEF_DW-1:0] wdata;
    } req_t;

endpackage

// File: rtl/mram_rr_arb2.sv
// Two-way arbiter: port 0 preferred, but port 1 wins after it has lost once to port 0.
module mram_rr_arb2 (
    input  logic       SIM_CLK,
    input  logic       SIM_RST,
    input  logic       en,
    input  logic [1:0] req,
    output logic       gnt,
    output logic [1:0] ready
);

    logic p1_wait;

    always_comb begin
        gnt   = req[1] & (~req[0] | p1_wait);
        ready = 2'b00;
        if (en && (req != 2'b00))
            ready = gnt ? 2'b10 : 2'b01;
    end

    // Set when port 0 is granted over a pending port 1; any other grant clears it.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST)
            p1_wait <= 1'b0;
        else if (en && (req != 2'b00))
            p1_wait <= ~gnt & req[1];
    end

endmodule

// File: rtl/mram_seq_ctrl.sv
// Sequences MRAM E_n/G_n/W_n/LB_n/UB_n, address and DQ for two requesters.
// Optional write protection above wp_base is enabled by defining MRAM_WRITE_PROTECT_EN.
module mram_seq_ctrl
    import mram_ctrl_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int RD_WAIT  = DEF_RD_WAIT,
    parameter int WR_PULSE = DEF_WR_PULSE,
    parameter int SETUP    = DEF_SETUP,
    parameter int RECOVER  = DEF_RECOVER
) (
    input  logic          SIM_CLK,
    input  logic          SIM_RST,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic [1:0]    req0_be,
    output logic          req0_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    input  logic [1:0]    req1_be,
    output logic          req1_ready,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic [AW-1:0] mem_a,
    output logic          mem_e_n,
    output logic          mem_g_n,
    output logic          mem_w_n,
    output logic          mem_lb_n,
    output logic          mem_ub_n,
    output logic [DW-1:0] mem_dq_out,
    output logic          mem_dq_oe,
    input  logic [DW-1:0] mem_dq_in,
    output logic          busy
`ifdef MRAM_WRITE_PROTECT_EN
   ,input  logic [AW-1:0] wp_base,
    output logic          wp_err
`endif
);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [1:0]    be;
        logic [DW-1:0] wdata;
    } rec_t;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP   > 0) ? SETUP   - 1 : 0);
    localparam logic [CNT_W-1:0] RD_LD    = CNT_W'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);
    localparam logic [CNT_W-1:0] WR_LD    = CNT_W'((WR_PULSE > 0) ? WR_PULSE - 1 : 0);
    localparam logic [CNT_W-1:0] REC_LD   = CNT_W'((RECOVER > 0) ? RECOVER - 1 : 0);

    state_t           state, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    rec_t             win;
    logic             we_q, owner_q, wp_q, wp_hit;
    logic [1:0]       be_q, ready, act_be;
    logic             gnt, arb_en, take, act_we, act_wp, in_acc;

    assign arb_en = (state == ST_IDLE) & ~SIM_RST;

    mram_rr_arb2 u_arb (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .en      (arb_en),
        .req     ({req1_valid, req0_valid}),
        .gnt     (gnt),
        .ready   (ready)
    );

    assign take       = |ready;
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign win        = gnt ? {req1_we, req1_addr, req1_be, req1_wdata}
                            : {req0_we, req0_addr, req0_be, req0_wdata};

`ifdef MRAM_WRITE_PROTECT_EN
    assign wp_hit = win.we & (win.addr >= wp_base);
    assign wp_err = (state == ST_WR_HOLD) & wp_q;
`else
    assign wp_hit = 1'b0;
`endif

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        unique case (state)
            ST_IDLE: if (take) begin
                if (wp_hit) nxt = ST_WR_HOLD;
                else if (SETUP > 0) begin nxt = ST_SETUP; cnt_nxt = SETUP_LD; end
                else if (win.we) begin nxt = ST_WR_PULSE; cnt_nxt = WR_LD; end
                else begin nxt = ST_RD_ACC; cnt_nxt = RD_LD; end
            end
            ST_SETUP: begin
                if (cnt != '0) cnt_nxt = cnt - 1'b1;
                else if (we_q) begin nxt = ST_WR_PULSE; cnt_nxt = WR_LD; end
                else begin nxt = ST_RD_ACC; cnt_nxt = RD_LD; end
            end
            ST_RD_ACC: begin
                if (cnt != '0) cnt_nxt = cnt - 1'b1;
                else nxt = ST_RD_DONE;
            end
            ST_WR_PULSE: begin
                if (cnt != '0) cnt_nxt = cnt - 1'b1;
                else nxt = ST_WR_HOLD;
            end
            ST_RD_DONE, ST_WR_HOLD: begin
                nxt     = (RECOVER > 0) ? ST_RECOVER : ST_IDLE;
                cnt_nxt = REC_LD;
            end
            ST_RECOVER: begin
                if (cnt != '0) cnt_nxt = cnt - 1'b1;
                else nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they change only on clock edges.
    always_comb begin
        act_we = (state == ST_IDLE) ? win.we : we_q;
        act_be = (state == ST_IDLE) ? win.be : be_q;
        act_wp = (state == ST_IDLE) ? wp_hit : wp_q;
        in_acc = (nxt != ST_IDLE) && (nxt != ST_RECOVER) && !act_wp;
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            be_q       <= 2'b00;
            owner_q    <= 1'b0;
            wp_q       <= 1'b0;
            mem_e_n    <= 1'b1;
            mem_g_n    <= 1'b1;
            mem_w_n    <= 1'b1;
            mem_lb_n   <= 1'b1;
            mem_ub_n   <= 1'b1;
            mem_dq_oe  <= 1'b0;
            mem_a      <= '0;
            mem_dq_out <= '0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_nxt;
            mem_e_n   <= ~in_acc;
            mem_g_n   <= ~(nxt == ST_RD_ACC);
            mem_w_n   <= ~(nxt == ST_WR_PULSE);
            mem_lb_n  <= ~(in_acc & act_be[0]);
            mem_ub_n  <= ~(in_acc & act_be[1]);
            mem_dq_oe <= in_acc & act_we;
            if (take) begin
                we_q       <= win.we;
                be_q       <= win.be;
                owner_q    <= gnt;
                wp_q       <= wp_hit;
                mem_a      <= win.addr;
                mem_dq_out <= win.wdata;
            end
            if ((state == ST_RD_ACC) && (cnt == '0)) begin
                if (owner_q) rsp1_rdata <= mem_dq_in;
                else         rsp0_rdata <= mem_dq_in;
            end
        end
    end

    assign rsp0_valid = ((state == ST_RD_DONE) || (state == ST_WR_HOLD)) && !owner_q;
    assign rsp1_valid = ((state == ST_RD_DONE) || (state == ST_WR_HOLD)) &&  owner_q;
    assign busy       = (state != ST_IDLE);

endmodule
